pad_cfg_ctrl: RTL and testbench

Sequences configuration changes onto the `padring` pad controls (`pad_out_i`, `pad_oe_i`, `pad_attr_i`) and owns the per-pad registered state that drives them. Every reconfiguration of a pad is applied break-before-make: an enabled driver is turned off, left to settle, reconfigured, and only then re-enabled. This prevents glitches and contention on the bidirectional pads. The block sits between a single configuration requester (register block or boot sequencer) and `padring`.

---
 rtl/pad_cfg_ctrl_pkg.sv | 25 ++
 rtl/prim_pad_wrapper_pkg.sv | 27 ++
 rtl/pad_cfg_ctrl.sv | 125 ++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_cfg_ctrl_pkg
// Description : FSM encoding and settle-time bounds for pad_cfg_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package pad_cfg_ctrl_pkg;

  // Legal range of the settle time; the counter below must hold MAX-1.
  localparam int unsigned SETTLE_CYCLES_MIN = 1;
  localparam int unsigned SETTLE_CYCLES_MAX = 15;

  // Width of the settle counter.
  localparam int unsigned CNT_W = 4;

  // Controller states.
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BREAK  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_APPLY  = 3'd3;
  localparam logic [2:0] ST_ENABLE = 3'd4;

endpackage : pad_cfg_ctrl_pkg
`default_nettype wire

// File: rtl/prim_pad_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prim_pad_wrapper_pkg
// Description : Pad attribute type shared by the pad wrappers, the padring
//               and the pad configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package prim_pad_wrapper_pkg;

  // Per-pad electrical attributes; LSB first: invert, virt_od_en, pull_en,
  // pull_select, keeper_en, schmitt_en, od_en, input_disable, slew_rate,
  // drive_strength.
  typedef struct packed {
    logic [3:0] drive_strength;
    logic [1:0] slew_rate;
    logic       input_disable;
    logic       od_en;
    logic       schmitt_en;
    logic       keeper_en;
    logic       pull_select;
    logic       pull_en;
    logic       virt_od_en;
    logic       invert;
  } pad_attr_t;

endpackage : prim_pad_wrapper_pkg
`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pad_cfg_ctrl
// Description : Break-before-make sequencer for pad configuration changes.
//               Owns the registered out/oe/attr state of every pad; a driving
//               pad is disabled, left to settle, reconfigured and then
//               re-enabled so the bidirectional pads never glitch or fight.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_cfg_ctrl
  import prim_pad_wrapper_pkg::*;
  import pad_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NPads        = 64,
  parameter int unsigned SettleCycles = 4,   // 1..15
  parameter int unsigned IdxW         = $clog2(NPads)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IdxW-1:0]             req_idx_i,
  input  logic                        req_out_i,
  input  logic                        req_oe_i,
  input  pad_attr_t                   req_attr_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic [NPads-1:0]            pad_out_o,
  output logic [NPads-1:0]            pad_oe_o,
  output pad_attr_t [NPads-1:0]       pad_attr_o
);

  // Pad count widened by one bit so out-of-range indices compare cleanly.
  localparam logic [IdxW:0]      NPADS_EXT   = (IdxW + 1)'(NPads);
  // The counter is loaded with S-1 and leaves SETTLE on zero: S cycles total.
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SettleCycles - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  logic [STATE_W-1:0] state;
  logic [IdxW-1:0]    idx_q;
  logic               out_q;
  logic               oe_q;
  pad_attr_t          attr_q;
  logic [CNT_W-1:0]   cnt;

  logic accept;
  logic idx_ok;

  // Ready is forced low during reset so nothing is accepted while clearing.
  assign req_ready_o = (state == ST_IDLE) && !rst_i;
  assign busy_o      = (state != ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign idx_ok      = ({1'b0, req_idx_i} < NPADS_EXT);

  // Sequencer: FSM, request latch, settle counter, pad registers and pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      idx_q      <= '0;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      attr_q     <= '0;
      cnt        <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      pad_out_o  <= '0;
      pad_oe_o   <= '0;
      pad_attr_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!idx_ok) begin
              // Rejected requests never touch pad state and keep us in IDLE.
              err_o <= 1'b1;
            end else begin
              idx_q  <= req_idx_i;
              out_q  <= req_out_i;
              oe_q   <= req_oe_i;
              attr_q <= req_attr_i;
              // A driving pad always goes through the break, even if the new
              // configuration happens to match the old one.
              state  <= pad_oe_o[req_idx_i] ? ST_BREAK : ST_APPLY;
            end
          end
        end
        ST_BREAK: begin
          pad_oe_o[idx_q] <= 1'b0;
          cnt             <= SETTLE_LOAD;
          state           <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_APPLY;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_APPLY: begin
          pad_attr_o[idx_q] <= attr_q;
          pad_out_o[idx_q]  <= out_q;
          if (oe_q) begin
            state <= ST_ENABLE;
          end else begin
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_ENABLE: begin
          pad_oe_o[idx_q] <= 1'b1;
          done_o          <= 1'b1;
          state           <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : pad_cfg_ctrl
`default_nettype wire

// File: tb/tb_pad_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_cfg_ctrl
// Description : Self-checking bench for pad_cfg_ctrl. A 64-pad instance covers
//               the sequencing; a 40-pad instance covers index rejection.
//               Expected responses are queued at issue time and popped by a
//               monitor whenever a DUT pulses done_o or err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_cfg_ctrl;
  import prim_pad_wrapper_pkg::*;

  localparam int NA = 64;
  localparam int NB = 40;
  localparam int S  = 4;

  localparam pad_attr_t ATTR_INV = pad_attr_t'(14'h0001);  // invert
  localparam pad_attr_t ATTR_B   = pad_attr_t'(14'h0C04);  // drive 3, pull_en

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic             va, ra, oa, oea, done_a, err_a, busy_a;
  logic [5:0]       ia;
  pad_attr_t        aa;
  logic [NA-1:0]    pout_a, poe_a;
  pad_attr_t [NA-1:0] pattr_a;

  // Instance B signals
  logic             vb, rb, ob, oeb, done_b, err_b, busy_b;
  logic [5:0]       ib;
  pad_attr_t        ab;
  logic [NB-1:0]    pout_b, poe_b;
  pad_attr_t [NB-1:0] pattr_b;

  pad_cfg_ctrl #(.NPads(NA), .SettleCycles(S)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(va), .req_ready_o(ra), .req_idx_i(ia),
    .req_out_i(oa), .req_oe_i(oea), .req_attr_i(aa),
    .done_o(done_a), .err_o(err_a), .busy_o(busy_a),
    .pad_out_o(pout_a), .pad_oe_o(poe_a), .pad_attr_o(pattr_a)
  );

  pad_cfg_ctrl #(.NPads(NB), .SettleCycles(S)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vb), .req_ready_o(rb), .req_idx_i(ib),
    .req_out_i(ob), .req_oe_i(oeb), .req_attr_i(ab),
    .done_o(done_b), .err_o(err_b), .busy_o(busy_b),
    .pad_out_o(pout_b), .pad_oe_o(poe_b), .pad_attr_o(pattr_b)
  );

  typedef struct {
    bit                 is_err;
    int                 cyc;
    logic [63:0]        out;
    logic [63:0]        oe;
    pad_attr_t [63:0]   attr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [63:0]      ma_out, ma_oe, mb_out, mb_oe;
  pad_attr_t [63:0] ma_attr, mb_attr;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_attr(string name, pad_attr_t [63:0] act, pad_attr_t [63:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = 63; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: pad %0d attr got %h expected %h at cycle %0d",
               name, bad, act[bad], exp[bad], cyc);
    end
  endtask

  task automatic cmp_entry(string tag, exp_t e, logic is_err, logic [63:0] o,
                           logic [63:0] oe, pad_attr_t [63:0] at);
    chk({tag, "_resp_kind"},  64'(is_err), 64'(e.is_err));
    chk({tag, "_resp_cycle"}, 64'(cyc),    64'(e.cyc));
    chk({tag, "_pad_out"},    o,           e.out);
    chk({tag, "_pad_oe"},     oe,          e.oe);
    chk_attr({tag, "_pad_attr"}, at, e.attr);
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    pad_attr_t [63:0] tb_attr;
    if (done_a || err_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_resp: got done=%0b err=%0b expected none at cycle %0d",
                 done_a, err_a, cyc);
      end else begin
        cmp_entry("a", q_a.pop_front(), err_a, pout_a, poe_a, pattr_a);
      end
    end
    if (done_b || err_b) begin
      tb_attr = '0;
      tb_attr[NB-1:0] = pattr_b;
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_resp: got done=%0b err=%0b expected none at cycle %0d",
                 done_b, err_b, cyc);
      end else begin
        cmp_entry("b", q_b.pop_front(), err_b, {24'b0, pout_b}, {24'b0, poe_b}, tb_attr);
      end
    end
  end

  // Wait until the negedge of cycle n.
  task automatic at_cyc(int n);
    while (cyc < n) @(negedge clk);
    if (clk) @(negedge clk);
  endtask

  task automatic issue_a(int idx, logic o, logic oe, pad_attr_t at, bit expect_done,
                         output int t);
    exp_t e;
    int   lat;
    chk("a_ready_at_issue", 64'(ra), 64'd1);
    t = cyc;
    va = 1'b1; ia = 6'(idx); oa = o; oea = oe; aa = at;
    lat = ma_oe[idx] ? (4 + S) : 3;
    if (!oe) lat--;
    ma_out[idx] = o; ma_attr[idx] = at; ma_oe[idx] = oe;
    if (expect_done) begin
      e.is_err = 1'b0; e.cyc = t + lat;
      e.out = ma_out; e.oe = ma_oe; e.attr = ma_attr;
      q_a.push_back(e);
    end
    @(posedge clk); #1;
    va = 1'b0;
  endtask

  task automatic issue_b(int idx, logic o, logic oe, pad_attr_t at, output int t);
    exp_t e;
    chk("b_ready_at_issue", 64'(rb), 64'd1);
    t = cyc;
    vb = 1'b1; ib = 6'(idx); ob = o; oeb = oe; ab = at;
    if (idx >= NB) begin
      e.is_err = 1'b1; e.cyc = t + 1;
    end else begin
      e.is_err = 1'b0;
      e.cyc = t + (mb_oe[idx] ? (4 + S) : 3) - (oe ? 0 : 1);
      mb_out[idx] = o; mb_attr[idx] = at; mb_oe[idx] = oe;
    end
    e.out = mb_out; e.oe = mb_oe; e.attr = mb_attr;
    q_b.push_back(e);
    @(posedge clk); #1;
    vb = 1'b0;
  endtask

  // Bounded wait for all queued responses.
  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_pending"}, 64'(q_a.size() + q_b.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, t2;
    va = 0; ia = '0; oa = 0; oea = 0; aa = '0;
    vb = 0; ib = '0; ob = 0; oeb = 0; ab = '0;
    ma_out = '0; ma_oe = '0; ma_attr = '0;
    mb_out = '0; mb_oe = '0; mb_attr = '0;

    // Reset and idle state
    repeat (3) @(negedge clk);
    chk("rst_ready_low", 64'(ra), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_a", 64'(ra), 64'd1);
    chk("reset_ready_b", 64'(rb), 64'd1);
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_done_err_a", {62'b0, done_a, err_a}, 64'd0);
    chk("reset_pad_out_a", pout_a, 64'd0);
    chk("reset_pad_oe_a", poe_a, 64'd0);
    chk_attr("reset_pad_attr_a", pattr_a, '0);

    // Idx 5, pad idle, enable with invert
    issue_a(5, 1'b1, 1'b1, ATTR_INV, 1'b1, t);
    at_cyc(t + 1);
    chk("p5_busy_t1", 64'(busy_a), 64'd1);
    chk("p5_ready_t1", 64'(ra), 64'd0);
    chk("p5_attr_old_t1", 64'(pattr_a[5]), 64'd0);
    at_cyc(t + 2);
    chk("p5_out_t2", 64'(pout_a[5]), 64'd1);
    chk("p5_attr_t2", 64'(pattr_a[5]), 64'(ATTR_INV));
    chk("p5_oe_t2", 64'(poe_a[5]), 64'd0);
    at_cyc(t + 3);
    chk("p5_ready_t3", 64'(ra), 64'd1);
    drain("p5", 20);

    // Idx 5 again while driving: break, settle 4, apply, enable
    issue_a(5, 1'b0, 1'b1, ATTR_B, 1'b1, t);
    at_cyc(t + 1);
    chk("p5b_oe_t1", 64'(poe_a[5]), 64'd1);
    for (int k = 2; k <= 7; k++) begin
      at_cyc(t + k);
      chk($sformatf("p5b_oe_low_t%0d", k), 64'(poe_a[5]), 64'd0);
      if (k == 6) chk("p5b_attr_old_t6", 64'(pattr_a[5]), 64'(ATTR_INV));
      if (k == 7) chk("p5b_attr_new_t7", 64'(pattr_a[5]), 64'(ATTR_B));
    end
    drain("p5b", 20);

    // Idx 7 enabled, then reconfigured with oe=0
    issue_a(7, 1'b0, 1'b1, ATTR_INV, 1'b1, t);
    drain("p7a", 20);
    issue_a(7, 1'b1, 1'b0, ATTR_B, 1'b1, t);
    at_cyc(t + 2);
    chk("p7_oe_drop_t2", 64'(poe_a[7]), 64'd0);
    at_cyc(t + 6);
    chk("p7_out_old_t6", 64'(pout_a[7]), 64'd0);
    at_cyc(t + 7);
    chk("p7_out_new_t7", 64'(pout_a[7]), 64'd1);
    chk("p7_attr_new_t7", 64'(pattr_a[7]), 64'(ATTR_B));
    at_cyc(t + 8);
    chk("p7_oe_stays_low_t8", 64'(poe_a[7]), 64'd0);
    chk("p7_idle_t8", 64'(busy_a), 64'd0);
    drain("p7b", 20);

    // 40-pad instance: back-to-back rejects, then a valid top index
    issue_b(45, 1'b1, 1'b1, ATTR_INV, t);
    issue_b(63, 1'b1, 1'b1, ATTR_B, t2);
    chk("b_back_to_back", 64'(t2 - t), 64'd1);
    at_cyc(t + 2);
    chk("b_ready_after_err", 64'(rb), 64'd1);
    chk("b_busy_after_err", 64'(busy_b), 64'd0);
    issue_b(39, 1'b1, 1'b1, ATTR_B, t);
    drain("b39", 20);

    // Reset during SETTLE of idx 3
    issue_a(3, 1'b1, 1'b1, ATTR_INV, 1'b1, t);
    drain("p3a", 20);
    issue_a(3, 1'b0, 1'b1, ATTR_B, 1'b0, t);
    at_cyc(t + 3);
    chk("p3_in_settle_oe", 64'(poe_a[3]), 64'd0);
    chk("p3_in_settle_busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ma_out = '0; ma_oe = '0; ma_attr = '0;
    mb_out = '0; mb_oe = '0; mb_attr = '0;
    at_cyc(t + 4);
    chk("midrst_pad_out", pout_a, 64'd0);
    chk("midrst_pad_oe", poe_a, 64'd0);
    chk_attr("midrst_pad_attr", pattr_a, '0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_done", 64'(done_a), 64'd0);
    chk("midrst_ready", 64'(ra), 64'd1);
    chk("midrst_b_pad_oe", {24'b0, poe_b}, 64'd0);
    issue_a(3, 1'b1, 1'b1, ATTR_B, 1'b1, t);
    drain("p3c", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pad_cfg_ctrl
`default_nettype wire
